// File: rtl/mem_sweep_engine.sv
// Block-RAM sweep sequencer: fills an address window with seed+k or reads it back
// into a 32-bit running checksum. Window addresses wrap modulo DEPTH_MEM.
module mem_sweep_engine #(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [WID_MEM-1:0]  seed,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [WID_MEM-1:0]  mem_din,
  output logic                mem_we,
  input  logic [WID_MEM-1:0]  mem_dout,
  output logic                busy,
  output logic                done,
  output logic [31:0]         checksum
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_MEM);

  logic [2:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   k;
  logic              rd_valid;
  logic [ADDR_W:0]   len_sat;
  logic              last;

  assign len_sat = (length > DEPTH_L) ? DEPTH_L : length;
  assign last    = (k == len_q - 1'b1);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  // Address/data registers advance in place; natural overflow gives the window wrap
  // and the mod 2^WID_MEM pattern. rd_valid marks that mem_dout holds a window word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      k         <= '0;
      rd_valid  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      checksum  <= '0;
    end else begin
      rd_valid <= (state == S_READ);
      if (rd_valid)
        checksum <= checksum + 32'(mem_dout);

      case (state)
        S_IDLE: begin
          if (start) begin
            checksum <= '0;
            k        <= '0;
            len_q    <= len_sat;
            if (len_sat == '0) begin
              state <= S_DONE;
            end else if (mode) begin
              state     <= S_FILL;
              mem_we    <= 1'b1;
              mem_waddr <= base_addr;
              mem_din   <= seed;
            end else begin
              state     <= S_READ;
              mem_raddr <= base_addr;
            end
          end
        end
        S_FILL: begin
          if (last) begin
            mem_we <= 1'b0;
            state  <= S_DONE;
          end else begin
            k         <= k + 1'b1;
            mem_waddr <= mem_waddr + 1'b1;
            mem_din   <= mem_din + 1'b1;
          end
        end
        S_READ: begin
          if (last) begin
            state <= S_DRAIN;
          end else begin
            k         <= k + 1'b1;
            mem_raddr <= mem_raddr + 1'b1;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweep_engine.sv
// Self-checking bench for mem_sweep_engine: behavioural RAM plus an array
// reference of expected contents, directed spec cases and randomized windows.
module tb_mem_sweep_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic [15:0] seed;
  logic [11:0] mem_raddr;
  logic [11:0] mem_waddr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;
  int ref_mem [4096];
  logic [15:0] ram [4096];

  always #5 clk = ~clk;

  mem_sweep_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length), .seed(seed),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .busy(busy), .done(done),
    .checksum(checksum)
  );

  // Single-clock RAM with a registered read port
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start, then watch until done; checks every write against seed+k at base+k.
  task automatic applyStimulus(input logic m, input int b, input int len, input int s,
                               input int poke_at, output int lat, output int wes);
    lat = -1;
    wes = 0;
    @(negedge clk);
    start = 1'b1; mode = m; base_addr = 12'(b); length = 13'(len); seed = 16'(s);
    @(negedge clk);
    start = 1'b0;
    base_addr = 12'($urandom); length = 13'($urandom); seed = 16'($urandom); mode = 1'($urandom);
    for (int n = 1; n <= 8300; n++) begin
      if (mem_we) begin
        checkOutput("waddr", 32'(mem_waddr), 32'((b + wes) % 4096));
        checkOutput("din", 32'(mem_din), 32'((s + wes) & 16'hFFFF));
        wes++;
      end
      if (done) begin
        lat = n;
        break;
      end
      if (n == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic doSweep(input logic m, input int b, input int len, input int s,
                         input int poke_at, input string tag);
    int eff, lat, wes, exp_lat;
    logic [31:0] sum;
    eff = (len > 4096) ? 4096 : len;
    applyStimulus(m, b, len, s, poke_at, lat, wes);
    exp_lat = (eff == 0) ? 1 : (m ? eff + 1 : eff + 2);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_we_cycles"}, 32'(wes), m ? 32'(eff) : 32'd0);
    if (m) begin
      for (int k = 0; k < eff; k++) ref_mem[(b + k) % 4096] = (s + k) & 16'hFFFF;
    end else begin
      sum = 32'd0;
      for (int k = 0; k < eff; k++) sum = sum + 32'(ref_mem[(b + k) % 4096]);
      checkOutput({tag, "_checksum"}, checksum, sum);
    end
    @(negedge clk);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int wes;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    base_addr = '0; length = '0; seed = '0;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_checksum", checksum, 32'd0);
    checkOutput("rst_addr", {8'd0, mem_raddr, mem_waddr}, 32'd0);
    checkOutput("rst_din", 32'(mem_din), 32'd0);
    reset = 1'b1;

    doSweep(1'b1, 0, 8, 16'h1000, 0, "fill8");
    doSweep(1'b0, 0, 8, 0, 0, "read8");
    checkOutput("read8_const", checksum, 32'h0000801C);

    doSweep(1'b1, 4094, 4, 0, 0, "fillwrap");
    doSweep(1'b0, 4094, 4, 0, 0, "readwrap");
    checkOutput("readwrap_const", checksum, 32'd6);

    doSweep(1'b0, 17, 0, 0, 0, "len0");
    checkOutput("len0_const", checksum, 32'd0);
    doSweep(1'b0, 0, 8, 0, 3, "poke_read");
    doSweep(1'b1, 200, 10, 16'hFFFC, 5, "poke_fill");
    doSweep(1'b0, 200, 10, 0, 1, "readback");

    // Reset dropped in the third FILL cycle of a 16-word sweep
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 12'd100; length = 13'd16; seed = 16'h55;
    @(negedge clk);
    start = 1'b0;
    wes = 0;
    for (int n = 1; n <= 3; n++) begin
      if (mem_we) wes++;
      if (n == 3) reset = 1'b0;
      @(negedge clk);
    end
    checkOutput("abort_we", 32'(mem_we), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_words", 32'(wes), 32'd3);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) ref_mem[100 + k] = 16'h55 + k;
    doSweep(1'b0, 100, 3, 0, 0, "after_abort");
    checkOutput("after_abort_const", checksum, 32'h00000102);

    for (int i = 0; i < 6; i++) begin
      int b, len, s;
      b = $urandom_range(0, 4095);
      len = $urandom_range(0, 40);
      s = $urandom_range(0, 65535);
      doSweep(1'b1, b, len, s, $urandom_range(0, 45), "rnd_fill");
      doSweep(1'b0, b, len, 0, $urandom_range(0, 45), "rnd_read");
    end

    doSweep(1'b1, 0, 4096, 0, 0, "full_fill");
    doSweep(1'b0, 0, 4096, 0, 0, "full_read");
    checkOutput("full_read_const", checksum, 32'h007FF800);
    doSweep(1'b0, $urandom_range(0, 4095), 5000, 0, 0, "sat_read");
    checkOutput("sat_read_const", checksum, 32'h007FF800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
